arf028b032e2r2w0cbbehraa4acw_wr_arb: RTL and testbench

// - Write-port arbiter for the 28-entry x 32-bit, 2-write-port register file array.
// - Shares the two array write ports between NUM_REQ write requesters with round-robin fairness.
// - Suppresses same-address double writes and drops out-of-range writes with a sticky error flag.
// - Sits between the requester write paths and the array write-port flops.

---
 rtl/arf028b032e2r2w0cbbehraa4acw_wr_arb.sv | 167 ++++++++++++++++
 tb/tb_arf028b032e2r2w0cbbehraa4acw_wr_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/arf028b032e2r2w0cbbehraa4acw_wr_arb.sv
// Write-port arbiter for the 28x32 register file array with two write ports.
// Shares the two array write ports between NUM_REQ requesters, using a round-robin
// start pointer. Same-address double writes are deferred and counted in a saturating
// counter. Out-of-range writes are acknowledged, dropped and flagged in a sticky bit.
// Optional build macro ARF028B032E2R2W0CBBEHRAA4ACW_WR_ARB_PIPE_EN registers the wp_*
// outputs, which adds one cycle of latency. Without the macro, wp_* are combinational.
module arf028b032e2r2w0cbbehraa4acw_wr_arb #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned NUM_ENTRIES = 28,
   parameter int unsigned AWIDTH      = 5,
   parameter int unsigned DWIDTH      = 32,
   parameter int unsigned CWIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DWIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [1:0]                wp_en,
   output logic [2*AWIDTH-1:0]       wp_addr,
   output logic [2*DWIDTH-1:0]       wp_data,
   output logic                      err_oob,
   output logic [CWIDTH-1:0]         conflict_cnt
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0]       r_ptr;
   logic                r_err_oob;
   logic [CWIDTH-1:0]   r_conflict_cnt;

   logic [AWIDTH-1:0]   w_addr_arr [NUM_REQ];
   logic [DWIDTH-1:0]   w_data_arr [NUM_REQ];
   logic [NUM_REQ-1:0]  w_ready;
   logic [1:0]          w_en;
   logic [AWIDTH-1:0]   w_addr0;
   logic [AWIDTH-1:0]   w_addr1;
   logic [DWIDTH-1:0]   w_data0;
   logic [DWIDTH-1:0]   w_data1;
   logic                w_oob;
   int unsigned         w_sum;
   int unsigned         w_defer;
   logic [PW-1:0]       w_idx;
   logic [PW-1:0]       w_last;
   logic [PW-1:0]       w_ptr_nxt;
   logic [CWIDTH:0]     w_cnt_sum;
   logic [NUM_REQ-1:0]  w_ready_g;
   logic [1:0]          w_en_g;
   logic [2*AWIDTH-1:0] w_addr_g;
   logic [2*DWIDTH-1:0] w_data_g;

   // Unpack the flat requester buses into per-requester arrays
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_addr_arr[i] = req_addr[i*AWIDTH +: AWIDTH];
         w_data_arr[i] = req_data[i*DWIDTH +: DWIDTH];
      end
   end

   // Round-robin scan from r_ptr: fill port 0, then port 1, defer same-address hits, drop OOB
   always_comb begin
      w_ready = '0;
      w_en    = '0;
      w_addr0 = '0;
      w_addr1 = '0;
      w_data0 = '0;
      w_data1 = '0;
      w_oob   = 1'b0;
      w_defer = 0;
      w_sum   = 0;
      w_idx   = '0;
      w_last  = r_ptr;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_sum = 32'(r_ptr) + k;
         if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
         w_idx = PW'(w_sum);
         if (req_valid[w_idx]) begin
            if (32'(w_addr_arr[w_idx]) >= NUM_ENTRIES) begin
               w_ready[w_idx] = 1'b1;
               w_oob          = 1'b1;
            end else if (!w_en[0]) begin
               w_en[0]        = 1'b1;
               w_addr0        = w_addr_arr[w_idx];
               w_data0        = w_data_arr[w_idx];
               w_ready[w_idx] = 1'b1;
               w_last         = w_idx;
            end else if (!w_en[1]) begin
               // A deferral is counted only while port 1 is still being searched for
               if (w_addr_arr[w_idx] == w_addr0) begin
                  w_defer = w_defer + 1;
               end else begin
                  w_en[1]        = 1'b1;
                  w_addr1        = w_addr_arr[w_idx];
                  w_data1        = w_data_arr[w_idx];
                  w_ready[w_idx] = 1'b1;
                  w_last         = w_idx;
               end
            end
         end
      end
   end

   // Next pointer follows the last port-granted requester; holds when no port was granted
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_en[0]) begin
         if (32'(w_last) + 1 >= NUM_REQ) w_ptr_nxt = '0;
         else                            w_ptr_nxt = w_last + 1'b1;
      end
      w_cnt_sum = {1'b0, r_conflict_cnt} + (CWIDTH+1)'(w_defer);
   end

   // While reset is asserted, grants are suppressed combinationally
   always_comb begin
      w_ready_g = rst ? w_ready : '0;
      w_en_g    = rst ? w_en    : '0;
      w_addr_g  = rst ? {w_addr1, w_addr0} : '0;
      w_data_g  = rst ? {w_data1, w_data0} : '0;
   end

   // Arbitration state: round-robin pointer, sticky OOB flag, saturating conflict counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr          <= '0;
         r_err_oob      <= 1'b0;
         r_conflict_cnt <= '0;
      end else begin
         r_ptr     <= w_ptr_nxt;
         r_err_oob <= r_err_oob | w_oob;
         if (w_cnt_sum[CWIDTH]) r_conflict_cnt <= '1;
         else                   r_conflict_cnt <= w_cnt_sum[CWIDTH-1:0];
      end
   end

`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_WR_ARB_PIPE_EN
   logic [1:0]          r_wp_en;
   logic [2*AWIDTH-1:0] r_wp_addr;
   logic [2*DWIDTH-1:0] r_wp_data;

   // Write-port outputs registered one cycle after the handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp_en   <= '0;
         r_wp_addr <= '0;
         r_wp_data <= '0;
      end else begin
         r_wp_en   <= w_en_g;
         r_wp_addr <= w_addr_g;
         r_wp_data <= w_data_g;
      end
   end

   assign wp_en   = r_wp_en;
   assign wp_addr = r_wp_addr;
   assign wp_data = r_wp_data;
`else
   assign wp_en   = w_en_g;
   assign wp_addr = w_addr_g;
   assign wp_data = w_data_g;
`endif

   assign req_ready    = w_ready_g;
   assign err_oob      = r_err_oob;
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_arf028b032e2r2w0cbbehraa4acw_wr_arb.sv
// Directed self-checking bench for arf028b032e2r2w0cbbehraa4acw_wr_arb.
// Works with or without ARF028B032E2R2W0CBBEHRAA4ACW_WR_ARB_PIPE_EN. In the
// registered build, write-port expectations are sampled one cycle later.
module tb_arf028b032e2r2w0cbbehraa4acw_wr_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [19:0] req_addr;
   logic [127:0] req_data;
   logic [3:0]  req_ready;
   logic [1:0]  wp_en;
   logic [9:0]  wp_addr;
   logic [63:0] wp_data;
   logic        err_oob;
   logic [15:0] conflict_cnt;

   int n_checks = 0;
   int n_errors = 0;

   arf028b032e2r2w0cbbehraa4acw_wr_arb #(
      .NUM_REQ(4), .NUM_ENTRIES(28), .AWIDTH(5), .DWIDTH(32), .CWIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .wp_en(wp_en), .wp_addr(wp_addr),
      .wp_data(wp_data), .err_oob(err_oob), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid[i]          = v;
      req_addr[i*5 +: 5]    = a;
      req_data[i*32 +: 32]  = d;
   endtask

   // Called at posedge+2 with inputs already driven; returns at the next posedge+2
   task automatic cyc(input string tag, input logic [3:0] er, input logic [1:0] een,
                      input logic [9:0] ea, input logic [63:0] ed);
      #2;
      chk({tag, "_ready"}, 64'(req_ready), 64'(er));
`ifndef ARF028B032E2R2W0CBBEHRAA4ACW_WR_ARB_PIPE_EN
      chk({tag, "_wp_en"}, 64'(wp_en), 64'(een));
      chk({tag, "_wp_addr"}, 64'(wp_addr), 64'(ea));
      chk({tag, "_wp_data"}, wp_data, ed);
`endif
      @(posedge clk);
      #1;
`ifdef ARF028B032E2R2W0CBBEHRAA4ACW_WR_ARB_PIPE_EN
      chk({tag, "_wp_en"}, 64'(wp_en), 64'(een));
      chk({tag, "_wp_addr"}, 64'(wp_addr), 64'(ea));
      chk({tag, "_wp_data"}, wp_data, ed);
`endif
      #1;
   endtask

   localparam logic [31:0] D0 = 32'hD000_0000;
   localparam logic [31:0] D1 = 32'hD000_0001;
   localparam logic [31:0] D2 = 32'hD000_0002;
   localparam logic [31:0] D3 = 32'hD000_0003;

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 1'b1, 5'd1, D0);
      set_req(1, 1'b1, 5'd2, D1);
      set_req(2, 1'b1, 5'd3, D2);
      set_req(3, 1'b1, 5'd4, D3);
      #7;
      // Reset held with every requester valid
      cyc("rst", 4'b0000, 2'b00, 10'd0, 64'd0);
      chk("rst_err", 64'(err_oob), 64'd0);
      chk("rst_cnt", 64'(conflict_cnt), 64'd0);

      // Round-robin with distinct addresses 1..4, held
      rst = 1'b1;
      cyc("rr1", 4'b0011, 2'b11, {5'd2, 5'd1}, {D1, D0});
      cyc("rr2", 4'b1100, 2'b11, {5'd4, 5'd3}, {D3, D2});
      cyc("rr3", 4'b0011, 2'b11, {5'd2, 5'd1}, {D1, D0});
      cyc("rr4", 4'b1100, 2'b11, {5'd4, 5'd3}, {D3, D2});
      chk("rr_cnt", 64'(conflict_cnt), 64'd0);

      // Same-address conflict with ptr=0
      set_req(0, 1'b1, 5'd7, D0);
      set_req(1, 1'b1, 5'd7, D1);
      set_req(2, 1'b1, 5'd9, D2);
      set_req(3, 1'b0, 5'd0, 32'd0);
      cyc("cf1", 4'b0101, 2'b11, {5'd9, 5'd7}, {D2, D0});
      chk("cf1_cnt", 64'(conflict_cnt), 64'd1);
      set_req(0, 1'b0, 5'd0, 32'd0);
      set_req(2, 1'b0, 5'd0, 32'd0);
      cyc("cf2", 4'b0010, 2'b01, {5'd0, 5'd7}, {32'd0, D1});
      chk("cf2_cnt", 64'(conflict_cnt), 64'd1);

      // Out-of-range write from requester 1 alone
      set_req(1, 1'b1, 5'd28, D1);
      chk("oob_pre_err", 64'(err_oob), 64'd0);
      cyc("oob", 4'b0010, 2'b00, 10'd0, 64'd0);
      chk("oob_err", 64'(err_oob), 64'd1);
      set_req(1, 1'b0, 5'd0, 32'd0);
      cyc("idle", 4'b0000, 2'b00, 10'd0, 64'd0);
      chk("idle_err", 64'(err_oob), 64'd1);

      // Mixed: ptr=2, req0 OOB, req2/req3 granted, req1 left waiting
      set_req(0, 1'b1, 5'd30, D0);
      set_req(1, 1'b1, 5'd8, D1);
      set_req(2, 1'b1, 5'd5, D2);
      set_req(3, 1'b1, 5'd6, D3);
      cyc("mix", 4'b1101, 2'b11, {5'd6, 5'd5}, {D3, D2});
      chk("mix_cnt", 64'(conflict_cnt), 64'd1);
      chk("mix_err", 64'(err_oob), 64'd1);

      // Saturation: all four on address 7 gives three deferrals per cycle
      set_req(0, 1'b1, 5'd7, D0);
      set_req(1, 1'b1, 5'd7, D1);
      set_req(2, 1'b1, 5'd7, D2);
      set_req(3, 1'b1, 5'd7, D3);
      cyc("sat1", 4'b0001, 2'b01, {5'd0, 5'd7}, {32'd0, D0});
      chk("sat1_cnt", 64'(conflict_cnt), 64'd4);
      for (int i = 0; i < 21900; i++) @(posedge clk);
      #1;
      chk("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
      @(posedge clk);
      #1;
      chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
      #1;

      // Reset clears the sticky flag and the counter
      rst = 1'b0;
      #1;
      chk("rst2_ready", 64'(req_ready), 64'd0);
      chk("rst2_en", 64'(wp_en), 64'd0);
      chk("rst2_err", 64'(err_oob), 64'd0);
      chk("rst2_cnt", 64'(conflict_cnt), 64'd0);
      @(posedge clk);
      #2;

      // Single write: req0 addr 3, data DEADBEEF
      rst = 1'b1;
      req_valid = '0;
      set_req(0, 1'b1, 5'd3, 32'hDEADBEEF);
      cyc("single", 4'b0001, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hDEADBEEF});
      chk("single_err", 64'(err_oob), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
